sweep_scheduler: RTL
====================

SWEEP_SCHEDULER -- requirements
Module: sweep_scheduler

Interface
REQ-001 Parameter W, default 4, is the count and bound width.
REQ-002 Parameter LW, default 3, is the repeat-count width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  2  bit i = requester i presents a sweep command.
REQ-006 req_ready  output  2  bit i = command from requester i accepted this cycle.
REQ-007 req_lo  input  2*W  lower bounds, requester i in bits [i*W +: W].
REQ-008 req_hi  input  2*W  upper bounds, same packing.
REQ-009 req_mode  input  2  per requester: 0 = count up lo->hi, 1 = count down hi->lo.
REQ-010 req_loops  input  2*LW  per requester: extra repetitions (total sweeps = loops+1).
REQ-011 abort  input  1  terminates the active sweep.
REQ-012 count  output  W  shared counter value.
REQ-013 busy  output  1  high in RUN and DONE.
REQ-014 owner  output  1  requester owning the counter (valid while busy).
REQ-015 done  output  1  one-cycle pulse at end of command.
REQ-016 aborted  output  1  qualifies done: command ended by abort.
REQ-017 err  output  1  one-cycle pulse: accepted command rejected (lo > hi).

Function
REQ-018 FSM states SHALL be IDLE, RUN, DONE; reset state IDLE.
REQ-019 req_ready SHALL be combinational, non-zero only in IDLE, at most one bit set: the granted requester.
REQ-020 Grant: one valid -> that one; both valid -> requester != last_grant; last_grant updates on every handshake.
REQ-021 Handshake (valid & ready) in IDLE: latch lo, hi, mode, loops into internal registers, owner <= i, count <= (mode ? hi : lo).
REQ-022 If latched lo > hi (unsigned): err pulses next cycle, FSM stays IDLE, count unchanged, no done.
REQ-023 Else IDLE -> RUN; start = mode ? hi : lo, end = mode ? lo : hi.
REQ-024 RUN, count != end: count steps +1 (mode 0) or -1 (mode 1); never passes end, no wrap-around.
REQ-025 RUN, count == end, remaining loops > 0: count <= start, remaining decrements.
REQ-026 RUN, count == end, remaining == 0: -> DONE, count holds end.
REQ-027 One sweep of span L = hi-lo SHALL occupy exactly L+1 RUN cycles; lo == hi gives 1 cycle per sweep.
REQ-028 abort in RUN SHALL take priority over stepping: -> DONE with aborted = 1, count holds current value.
REQ-029 abort outside RUN SHALL be ignored.
REQ-030 DONE lasts exactly one cycle: done = 1, aborted per REQ-028, then -> IDLE.
REQ-031 No command accepted in RUN or DONE; requesters hold req_valid until req_ready.
REQ-032 count SHALL hold its last value in IDLE until the next accepted command.
REQ-033 done, err, aborted SHALL be registered outputs, low except on their pulse cycle.

Reset
REQ-034 rst SHALL asynchronously force: state IDLE, count 0, owner 0, busy 0, done 0, aborted 0, err 0, remaining 0, last_grant 1 (requester 0 wins first tie).
REQ-035 rst mid-RUN SHALL abandon the command without a done pulse.
REQ-036 req_ready SHALL be 0 while rst is high.

Verification
REQ-037 Req0 lo=3 hi=6 mode=0 loops=0 -> count 3,4,5,6,6; done=1 on the DONE cycle; aborted=0; owner=0.
REQ-038 Req1 lo=3 hi=6 mode=1 loops=1 -> count 6,5,4,3,6,5,4,3 then done; owner=1.
REQ-039 Both valid from reset release, held -> grants req0, req1, req0 on successive IDLE cycles; never two ready bits set.
REQ-040 Req0 lo=7 hi=2 -> ready handshake, err pulse one cycle, busy stays 0, count unchanged.
REQ-041 Req0 lo=0 hi=15 mode=0, abort when count=5 -> count holds 5, done=1 with aborted=1, then IDLE.
REQ-042 rst asserted mid-RUN at count=4 -> immediately count=0, busy=0, no done; after release req0 wins a tie.

Source files
------------

// File: rtl/sweep_scheduler.sv
// Two-requester sweep scheduler: grants one command at a time and steps a
// shared counter between the latched bounds, with repeats and abort.
module sweep_scheduler #(
  parameter int W  = 4,
  parameter int LW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [2*W-1:0]  req_lo,
  input  logic [2*W-1:0]  req_hi,
  input  logic [1:0]      req_mode,
  input  logic [2*LW-1:0] req_loops,
  input  logic            abort,
  output logic [W-1:0]    count,
  output logic            busy,
  output logic            owner,
  output logic            done,
  output logic            aborted,
  output logic            err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t r_state;
  state_t w_state_next;

  logic [W-1:0]  w_lo    [2];
  logic [W-1:0]  w_hi    [2];
  logic [LW-1:0] w_loops [2];

  logic [W-1:0]  r_lo;
  logic [W-1:0]  r_hi;
  logic          r_mode;
  logic [LW-1:0] r_rem;
  logic [W-1:0]  r_count;
  logic          r_owner;
  logic          r_last_grant;
  logic          r_done;
  logic          r_aborted;
  logic          r_err;

  logic          w_sel;
  logic          w_hs;
  logic          w_bad;
  logic [W-1:0]  w_start;
  logic [W-1:0]  w_end;
  logic          w_at_end;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign w_lo[gi]      = req_lo[gi*W +: W];
      assign w_hi[gi]      = req_hi[gi*W +: W];
      assign w_loops[gi]   = req_loops[gi*LW +: LW];
      assign req_ready[gi] = (r_state == IDLE) && !rst && req_valid[gi]
                             && (w_sel == 1'(gi));
    end
  endgenerate

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    w_sel = req_valid[1];
    if (req_valid == 2'b11) begin
      w_sel = ~r_last_grant;
    end
  end

  assign w_hs     = |req_ready;
  assign w_bad    = w_lo[w_sel] > w_hi[w_sel];
  assign w_start  = r_mode ? r_hi : r_lo;
  assign w_end    = r_mode ? r_lo : r_hi;
  assign w_at_end = (r_count == w_end);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_hs && !w_bad) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (abort || (w_at_end && (r_rem == '0))) begin
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lo         <= '0;
      r_hi         <= '0;
      r_mode       <= 1'b0;
      r_rem        <= '0;
      r_count      <= '0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_err     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_lo         <= w_lo[w_sel];
            r_hi         <= w_hi[w_sel];
            r_mode       <= req_mode[w_sel];
            r_rem        <= w_loops[w_sel];
            r_owner      <= w_sel;
            r_last_grant <= w_sel;
            if (w_bad) begin
              r_err <= 1'b1;
            end else begin
              r_count <= req_mode[w_sel] ? w_hi[w_sel] : w_lo[w_sel];
            end
          end
        end
        RUN: begin
          if (abort) begin
            r_done    <= 1'b1;
            r_aborted <= 1'b1;
          end else if (w_at_end) begin
            if (r_rem != '0) begin
              r_count <= w_start;
              r_rem   <= r_rem - 1'b1;
            end else begin
              r_done <= 1'b1;
            end
          end else if (r_mode) begin
            r_count <= r_count - 1'b1;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign count   = r_count;
  assign busy    = (r_state != IDLE);
  assign owner   = r_owner;
  assign done    = r_done;
  assign aborted = r_aborted;
  assign err     = r_err;

endmodule
